// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per clock, valid/ready on both sides.
// Optional two's-complement mode enabled by defining SEQ_MUL_SIGNED_EN.
module seq_mul #(
    parameter int unsigned N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   input1,
    input  logic [N-1:0]   input2,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic           signed_mode,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] mul_o,
    output logic           busy
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state, next_state;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] sum;
    logic [2*N-1:0] result;
    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic           accept;

`ifdef SEQ_MUL_SIGNED_EN
    logic neg;
    logic neg_d;
`endif

    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = (state == IDLE) && in_valid && in_ready;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = CALC;
            CALC:    if (cnt == CW'(1)) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Signed mode multiplies magnitudes; the sign is reapplied when the result is stored.
    always_comb begin
`ifdef SEQ_MUL_SIGNED_EN
        a_mag = (signed_mode && input1[N-1]) ? (~input1 + 1'b1) : input1;
        b_mag = (signed_mode && input2[N-1]) ? (~input2 + 1'b1) : input2;
        neg_d = signed_mode && (input1[N-1] ^ input2[N-1]);
`else
        a_mag = input1;
        b_mag = input2;
`endif
        sum = acc + (mplier[0] ? mcand : '0);
`ifdef SEQ_MUL_SIGNED_EN
        result = neg ? (~sum + 1'b1) : sum;
`else
        result = sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            mul_o    <= '0;
            acc      <= '0;
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            neg      <= 1'b0;
`endif
        end else begin
            state    <= next_state;
            // Registered so in_ready stays low for the first cycle after reset.
            in_ready <= (next_state == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= {{N{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        cnt    <= CW'(N);
`ifdef SEQ_MUL_SIGNED_EN
                        neg    <= neg_d;
`endif
                    end
                end
                CALC: begin
                    acc    <= sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) mul_o <= result;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul (N=16): stimulus pushes expected products,
// a negedge monitor pops and compares on each output handshake.
module tb_seq_mul;

    localparam int unsigned N = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   input1 = '0;
    logic [N-1:0]   input2 = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] mul_o;
    logic           busy;
`ifdef SEQ_MUL_SIGNED_EN
    logic           signed_mode = 1'b0;
`endif

    seq_mul #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .input1     (input1),
        .input2     (input2),
`ifdef SEQ_MUL_SIGNED_EN
        .signed_mode(signed_mode),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mul_o      (mul_o),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*N-1:0] exp;
        int unsigned    acc_cyc;
        bit             chk_lat;
    } item_t;

    item_t       sb[$];
    item_t       mon_it;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          b2b = 1'b0;
    bit          have_prev = 1'b0;
    int unsigned prev_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got 0x%0h expected no output", mul_o);
            end else begin
                mon_it = sb.pop_front();
                chk("product", 64'(mul_o), 64'(mon_it.exp));
                if (mon_it.chk_lat) chk("latency", 64'(cyc - mon_it.acc_cyc), 64'd16);
                if (b2b) begin
                    if (have_prev) chk("spacing", 64'(cyc - prev_cyc), 64'd18);
                    prev_cyc  = cyc;
                    have_prev = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input bit sm,
                        input logic [2*N-1:0] exp, input bit lat);
        item_t it;
        bit    done;
        done = 1'b0;
        input1 = a;
        input2 = b;
`ifdef SEQ_MUL_SIGNED_EN
        signed_mode = sm;
`endif
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                in_valid   = 1'b0;
                it.exp     = exp;
                it.acc_cyc = cyc;
                it.chk_lat = lat;
                sb.push_back(it);
                done = 1'b1;
            end
        end
        if (!done) begin
            in_valid = 1'b0;
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            if (sb.size() == 0) done = 1'b1;
        end
        #1;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_out();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_valid_timeout: got 0 expected 1 within 100 cycles");
        end
    endtask

    logic [N-1:0]   va [10] = '{16'h0001, 16'h0002, 16'h00FF, 16'h1000, 16'hFFFF,
                                16'h0010, 16'h8000, 16'h0100, 16'h000A, 16'hFFFF};
    logic [N-1:0]   vb [10] = '{16'h0001, 16'h8000, 16'h00FF, 16'h1000, 16'h0001,
                                16'h0010, 16'h8000, 16'h0100, 16'h000B, 16'h0002};
    logic [2*N-1:0] vp [10] = '{32'h00000001, 32'h00010000, 32'h0000FE01, 32'h01000000,
                                32'h0000FFFF, 32'h00000100, 32'h40000000, 32'h00010000,
                                32'h0000006E, 32'h0001FFFE};

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mul_o", 64'(mul_o), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        out_ready = 1'b1;
        send(16'd3, 16'd5, 1'b0, 32'h0000000F, 1'b1);
        drain();
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        send(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b1);
        drain();
        send(16'h0000, 16'hABCD, 1'b0, 32'h00000000, 1'b1);
        drain();

        out_ready = 1'b0;
        send(16'h1234, 16'h0100, 1'b0, 32'h00123400, 1'b0);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_mul_o", 64'(mul_o), 64'h00123400);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("handoff_out_valid", 64'(out_valid), 64'd0);
        chk("handoff_in_ready", 64'(in_ready), 64'd1);
        chk("handoff_mul_o_kept", 64'(mul_o), 64'h00123400);

        send(16'h1234, 16'h5678, 1'b0, 32'h06260060, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_mul_o", 64'(mul_o), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("midrst_in_ready_next", 64'(in_ready), 64'd1);
        send(16'd7, 16'd9, 1'b0, 32'd63, 1'b1);
        drain();

        b2b       = 1'b1;
        have_prev = 1'b0;
        for (int i = 0; i < 10; i++) send(va[i], vb[i], 1'b0, vp[i], 1'b1);
        drain();
        b2b = 1'b0;

`ifdef SEQ_MUL_SIGNED_EN
        send(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1'b1);
        drain();
        send(16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b1);
        drain();
        send(16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, 1'b1);
        drain();
        send(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b1);
        drain();
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
